// File: rtl/rf_wb_ctrl_pkg.sv
// Shared CPU definitions for the register-file write-port controller:
// register index width, the zero register and write-source encodings.
package rf_wb_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [31:0]      word_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MD   = 2'd2,
    SRC_LD   = 2'd3
  } src_e;

  function automatic logic is_zero(input reg_idx_t r);
    return r == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Bundle of writeback, MDU, load-return, scoreboard, decode and RF write-port
// signals around rf_wb_ctrl. The controller uses the slave side.
interface rf_wb_ctrl_if;
  import rf_wb_ctrl_pkg::*;

  logic     wb_we;
  reg_idx_t wb_dst;
  word_t    wb_data;

  logic     md_valid;
  logic     md_ready;
  reg_idx_t md_dst;
  word_t    md_data;

  logic     ld_valid;
  logic     ld_ready;
  reg_idx_t ld_dst;
  word_t    ld_data;

  logic     sb_set;
  reg_idx_t sb_dst;

  reg_idx_t id_rs;
  reg_idx_t id_rt;
  reg_idx_t id_wdst;
  logic     id_wen;
  logic     id_stall;

  logic     rf_we;
  reg_idx_t rf_wR;
  word_t    rf_wD;

  logic     sb_err;

  modport slave (
    input  wb_we, wb_dst, wb_data,
    input  md_valid, md_dst, md_data,
    output md_ready,
    input  ld_valid, ld_dst, ld_data,
    output ld_ready,
    input  sb_set, sb_dst,
    input  id_rs, id_rt, id_wdst, id_wen,
    output id_stall,
    output rf_we, rf_wR, rf_wD,
    output sb_err
  );

  modport master (
    output wb_we, wb_dst, wb_data,
    output md_valid, md_dst, md_data,
    input  md_ready,
    output ld_valid, ld_dst, ld_data,
    input  ld_ready,
    output sb_set, sb_dst,
    output id_rs, id_rt, id_wdst, id_wen,
    input  id_stall,
    input  rf_we, rf_wR, rf_wD,
    input  sb_err
  );

endinterface

// File: rtl/rf_wb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. Requests are valids, so any grant is a completed
// handshake and advances the last-served pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_reg;
  logic last_next;

  // last_reg=1 means side 1 was served last, so side 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (!hold) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_next = last_reg;
    if (gnt != 2'b00) begin
      last_next = gnt[1];
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: shares the RF write port between
// pipeline writeback, MDU and load return, and scoreboards long-latency results.
module rf_wb_ctrl
  import rf_wb_ctrl_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input logic            cpu_clk,
  input logic            cpu_rst_n,
  rf_wb_ctrl_if.slave    bus
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  logic          run;
  logic [1:0]    gnt;
  logic          md_hs;
  logic          ld_hs;
  logic          hs_any;
  reg_idx_t      hs_dst;
  logic          hs_hit;
  logic          clr_ok;
  logic          set_ok;
  logic          stall;
  src_e          src;
  reg_idx_t      w_dst;
  word_t         w_data;

  logic [31:0]   busy_reg;
  logic [31:0]   busy_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          err_reg;
  logic          err_next;

  assign run = cpu_rst_n;

  // Writeback owns the port outright; the arbiter only sees cycles it leaves free.
  rr_arb2 u_arb (
    .clk   (cpu_clk),
    .rst_n (cpu_rst_n),
    .hold  (~run | bus.wb_we),
    .req   ({bus.ld_valid, bus.md_valid}),
    .gnt   (gnt)
  );

  assign md_hs        = gnt[0];
  assign ld_hs        = gnt[1];
  assign bus.md_ready = md_hs;
  assign bus.ld_ready = ld_hs;

  always_comb begin
    src = SRC_NONE;
    if (run && bus.wb_we) begin
      src = SRC_WB;
    end else if (md_hs) begin
      src = SRC_MD;
    end else if (ld_hs) begin
      src = SRC_LD;
    end
  end

  always_comb begin
    w_dst  = REG_ZERO;
    w_data = '0;
    case (src)
      SRC_WB: begin w_dst = bus.wb_dst; w_data = bus.wb_data; end
      SRC_MD: begin w_dst = bus.md_dst; w_data = bus.md_data; end
      SRC_LD: begin w_dst = bus.ld_dst; w_data = bus.ld_data; end
      default: begin w_dst = REG_ZERO; w_data = '0; end
    endcase
  end

  assign bus.rf_we = (src != SRC_NONE) && !is_zero(w_dst);
  assign bus.rf_wR = w_dst;
  assign bus.rf_wD = w_data;

  assign hs_any = md_hs | ld_hs;
  assign hs_dst = md_hs ? bus.md_dst : bus.ld_dst;
  assign hs_hit = busy_reg[hs_dst];
  assign clr_ok = hs_any & hs_hit;

  // Hazard checks look only at registered busy: no same-cycle bypass of a clear.
  assign stall = run & (busy_reg[bus.id_rs]
                      | busy_reg[bus.id_rt]
                      | (bus.id_wen & busy_reg[bus.id_wdst])
                      | (bus.sb_set & (cnt_reg == CNT_MAX)));
  assign bus.id_stall = stall;

  assign set_ok = run & bus.sb_set & ~stall & !is_zero(bus.sb_dst);

  // Per-register update; a set to the same register as a clear wins.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign busy_next[gi] = (set_ok && (bus.sb_dst == reg_idx_t'(gi))) ? 1'b1 :
                               (clr_ok && (hs_dst == reg_idx_t'(gi)))     ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    case ({set_ok, clr_ok})
      2'b10:   cnt_next = cnt_reg + CW'(1);
      2'b01:   cnt_next = cnt_reg - CW'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  assign err_next = err_reg
                  | (hs_any & ~hs_hit)
                  | (run & bus.wb_we & busy_reg[bus.wb_dst]);
  assign bus.sb_err = err_reg;

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst_n) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
      err_reg  <= err_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: a cycle-by-cycle vector table plus a
// hand-written sequence for the outstanding-limit case.
module tb_rf_wb_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rf_wb_ctrl_if bus ();

  rf_wb_ctrl #(.MAX_OUT(4)) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        wb_we;  logic [4:0] wb_dst; logic [31:0] wb_data;
    logic        md_v;   logic [4:0] md_dst; logic [31:0] md_data;
    logic        ld_v;   logic [4:0] ld_dst; logic [31:0] ld_data;
    logic        sb_set; logic [4:0] sb_dst;
    logic [4:0]  rs;     logic [4:0] rt;     logic [4:0]  wdst; logic wen;
    logic [41:0] exp;    // {md_ready, ld_ready, rf_we, rf_wR, rf_wD, id_stall, sb_err}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r,
    input logic wb, input logic [4:0] wbd, input logic [31:0] wbx,
    input logic mv, input logic [4:0] mdd, input logic [31:0] mdx,
    input logic lv, input logic [4:0] ldd, input logic [31:0] ldx,
    input logic ss, input logic [4:0] sd,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wd, input logic wen,
    input logic e_mr, input logic e_lr, input logic e_we, input logic [4:0] e_wr,
    input logic [31:0] e_wd, input logic e_st, input logic e_er);
    vec_t v;
    v.rst_n = r;
    v.wb_we = wb; v.wb_dst = wbd; v.wb_data = wbx;
    v.md_v = mv;  v.md_dst = mdd; v.md_data = mdx;
    v.ld_v = lv;  v.ld_dst = ldd; v.ld_data = ldx;
    v.sb_set = ss; v.sb_dst = sd;
    v.rs = rs; v.rt = rt; v.wdst = wd; v.wen = wen;
    v.exp = {e_mr, e_lr, e_we, e_wr, e_wd, e_st, e_er};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n       = v.rst_n;
    bus.wb_we   = v.wb_we;  bus.wb_dst = v.wb_dst; bus.wb_data = v.wb_data;
    bus.md_valid = v.md_v;  bus.md_dst = v.md_dst; bus.md_data = v.md_data;
    bus.ld_valid = v.ld_v;  bus.ld_dst = v.ld_dst; bus.ld_data = v.ld_data;
    bus.sb_set  = v.sb_set; bus.sb_dst = v.sb_dst;
    bus.id_rs   = v.rs; bus.id_rt = v.rt; bus.id_wdst = v.wdst; bus.id_wen = v.wen;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  function automatic logic [41:0] outs();
    return {bus.md_ready, bus.ld_ready, bus.rf_we, bus.rf_wR, bus.rf_wD, bus.id_stall, bus.sb_err};
  endfunction

  // Advance one cycle: outputs were sampled on the falling edge before this.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t iv;

  initial begin
    iv = mk(0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    drive(iv);
    repeat (2) @(posedge clk);
    #1;

    //        rst wb  dst data           md  dst data           ld  dst data           ss sd  rs rt wd wen | mr lr we wr data           st er
    tbl.push_back(mk(0, 1, 1, 32'h1,        1, 2, 32'h2,        1, 3, 32'h3,        1, 2,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h1,        1, 2, 32'h2,        1, 3, 32'h3,        1, 2,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 8,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  8, 0, 0, 0,  0, 0, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 8, 32'hDEADBEEF, 0, 0, 32'h0,        0, 0,  8, 0, 0, 0,  1, 0, 1, 8, 32'hDEADBEEF, 1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  8, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 10, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 11, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 1, 5, 32'h11111111, 1, 10, 32'hAAAA0000, 1, 11, 32'hBBBB0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h11111111, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 10, 32'hAAAA0000, 1, 11, 32'hBBBB0000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 10, 32'hAAAA0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 11, 32'hBBBB0000, 0, 0, 0, 0, 0, 0,  0, 1, 1, 11, 32'hBBBB0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 12, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 13, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 14, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 15, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 12, 32'h1,       1, 13, 32'h2,       0, 0,  0, 0, 0, 0,  1, 0, 1, 12, 32'h1,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 14, 32'h3,       1, 13, 32'h2,       0, 0,  0, 0, 0, 0,  0, 1, 1, 13, 32'h2,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 14, 32'h3,       1, 15, 32'h4,       0, 0,  0, 0, 0, 0,  1, 0, 1, 14, 32'h3,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 15, 32'h4,       0, 0,  0, 0, 0, 0,  0, 1, 1, 15, 32'h4,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 0,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 32'h99,       0, 0,  0, 0, 0, 0,  0, 1, 1, 9, 32'h99,       0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(1, 1, 0, 32'h55,       0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 32'h55,       0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 3,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 3, 1,  0, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 3, 0,  0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        1, 3, 32'h33,       0, 0, 32'h0,        0, 0,  0, 0, 3, 1,  1, 0, 1, 3, 32'h33,       1, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 3, 1,  0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 7,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 7, 0, 0,  0, 0, 0, 0, 32'h0,        1, 1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 7, 0, 0,  0, 0, 0, 0, 32'h0,        0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  0, 7, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        1, 20, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk(1, 1, 20, 32'h2020,    0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  20, 0, 0, 0, 0, 0, 1, 20, 32'h2020,    1, 0));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0,  20, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
      step();
    end

    // Outstanding limit: four ops fill the scoreboard, a fifth waits for a return.
    iv = mk(0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    drive(iv);
    step();
    rst_n = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      bus.sb_set = 1'b1;
      bus.sb_dst = 5'(r);
      @(negedge clk);
      check($sformatf("full_issue_r%0d_stall", r), 64'(bus.id_stall), 64'd0);
      step();
    end
    bus.sb_dst = 5'd5;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("full_wait%0d_stall", k), 64'(bus.id_stall), 64'd1);
      step();
    end
    bus.md_valid = 1'b1;
    bus.md_dst   = 5'd1;
    bus.md_data  = 32'h0000_0001;
    @(negedge clk);
    check("full_return_ready", 64'(bus.md_ready), 64'd1);
    check("full_return_stall", 64'(bus.id_stall), 64'd1);
    step();
    bus.md_valid = 1'b0;
    @(negedge clk);
    check("full_r5_issue_stall", 64'(bus.id_stall), 64'd0);
    step();
    bus.sb_dst = 5'd6;
    @(negedge clk);
    check("full_again_stall", 64'(bus.id_stall), 64'd1);
    step();
    bus.sb_set = 1'b0;
    bus.id_rs  = 5'd5;
    @(negedge clk);
    check("raw_r5_stall", 64'(bus.id_stall), 64'd1);
    step();
    bus.id_rs = 5'd1;
    @(negedge clk);
    check("r1_cleared_stall", 64'(bus.id_stall), 64'd0);
    check("no_err_sb_err", 64'(bus.sb_err), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-port controller and scoreboard for the CPU register file. It shares the single RF write port between three writers: the in-order pipeline writeback, the multiply/divide unit and the load-return path. It also tracks destination registers with long-latency results outstanding and raises a decode-stage stall on RAW/WAW hazards. It sits between the writeback stage, the MDU and load-return logic, and the RF `we/wR/wD` inputs.

## Interface
- `MAX_OUT`, default 4: maximum long-latency ops outstanding, range 1..31.
- `cpu_clk` in 1: core clock; all state updates on the rising edge.
- `cpu_rst_n` in 1: synchronous, active-low reset.
- `wb_we` in 1: pipeline writeback request. Always granted, never back-pressured.
- `wb_dst` in 5, `wb_data` in 32: pipeline writeback destination and value.
- `md_valid` in 1, `md_ready` out 1: MDU result handshake.
- `md_dst` in 5, `md_data` in 32: MDU result destination and value.
- `ld_valid` in 1, `ld_ready` out 1: load-return handshake.
- `ld_dst` in 5, `ld_data` in 32: load-return destination and value.
- `sb_set` in 1: decode issues a long-latency op this cycle (qualified by `~id_stall`).
- `sb_dst` in 5: destination of the long-latency op being issued.
- `id_rs` in 5, `id_rt` in 5: decode-stage source registers.
- `id_wdst` in 5, `id_wen` in 1: decode-stage destination and its write enable.
- `id_stall` out 1: hold decode this cycle.
- `rf_we` out 1, `rf_wR` out 5, `rf_wD` out 32: drive the RF write port.
- `sb_err` out 1: sticky protocol-error flag.

## Operation
- State:
  - `busy[31:1]` scoreboard bits; `busy[0]` is constant 0.
  - `out_cnt`, 0..MAX_OUT.
  - `rr_last`, 1 bit: last granted side, 0=MDU, 1=load.
  - `sb_err`.
- Arbitration, all combinational:
  - `wb_we` has absolute priority. When it is high, `md_ready = ld_ready = 0`.
  - Otherwise, if only one of `md_valid`/`ld_valid` is high, that source gets ready.
  - If both are high, the side not equal to `rr_last` gets ready; the other waits.
  - `rr_last` updates only on a completed MDU/load handshake.
- RF drive:
  - `rf_we` is high when a write is granted and the granted destination is not 0.
  - `rf_wR`/`rf_wD` are muxed from the granted source, and are 0 when no write is granted.
  - A handshake to `$0` completes normally and is discarded.
- Scoreboard set: on `sb_set & ~id_stall & sb_dst!=0`, set `busy[sb_dst]` and increment `out_cnt`.
- Scoreboard clear:
  - A completed MDU/load handshake to a busy register clears `busy[dst]` and decrements `out_cnt`.
  - A handshake to a non-busy register (including `$0`) sets `sb_err`; `busy` and `out_cnt` are unchanged.
- Set and clear on the same edge: the counter nets to unchanged. If the register is the same, set wins. This cannot occur legally because of the WAW stall.
- `id_stall` asserts when any of these holds:
  - `busy[id_rs]` (RAW).
  - `busy[id_rt]` (RAW).
  - `id_wen & busy[id_wdst]` (WAW).
  - `sb_set & out_cnt==MAX_OUT` (full).
- All stall inputs use registered `busy`. A register cleared this cycle still stalls this cycle and reads the new RF value next cycle; no bypass.
- `wb_we` to a busy register sets `sb_err`. The write is still performed and `busy` is unchanged.

## Timing
- Reset values, synchronous, while `cpu_rst_n=0`:
  - `busy=0`, `out_cnt=0`, `rr_last=1` (MDU wins the first tie), `sb_err=0`.
  - Outputs `id_stall`, `md_ready`, `ld_ready` and `rf_we` are forced to 0 during reset.
- Latency:
  - Grant to RF write is 0 cycles; the RF latches on the same edge as the handshake.
  - Scoreboard update takes effect 1 cycle after the edge.
- Handshake rules:
  - A transfer occurs on an edge with `valid & ready`.
  - Sources hold `valid`, `dst` and `data` stable until accepted.
  - A waiting source is served within 2 non-`wb_we` cycles (round-robin).
- Reset mid-operation: all outstanding entries are dropped. Sources must also be reset; no replay.

## Structure
- Shared CPU package/defines header holds:
  - `REG_ZERO`
  - the register-index width (5)
  - source encodings `SRC_WB`, `SRC_MD`, `SRC_LD`
- One sub-module, `rr_arb2`: a 2-way round-robin arbiter with a `last` register, reused by other 2-master sharing points.
- Scoreboard, counter and muxing stay in the top level. Target size is about 200 lines.

## Test plan
- Reset: hold `cpu_rst_n=0` with all valids high. Required: `rf_we=0`, both readies 0, `id_stall=0`; after release, `busy=0`.
- Issue and clear:
  - Stimulus: `sb_set`, `sb_dst=8`; next cycle `id_rs=8`; MDU returns `md_dst=8`, `md_data=32'hDEADBEEF`.
  - Required: `id_stall=1` until the edge after the handshake; `rf_we=1`, `rf_wR=8`, `rf_wD=32'hDEADBEEF` on the handshake cycle.
- Priority and fairness:
  - Stimulus: `wb_we`, `md_valid` and `ld_valid` all high for 1 cycle, then `wb_we` low.
  - Required: the WB write goes first, then MDU, then load (with `rr_last=1` after reset).
  - With continuous `md_valid` and `ld_valid`, grants alternate.
- Full:
  - Stimulus: issue `MAX_OUT`=4 long ops to r1..r4, then `sb_set` to r5.
  - Required: `id_stall=1` until one result returns, then r5 issues.
- `$0` and error:
  - Stimulus: `sb_set` with `sb_dst=0`, then a load return to r9 when r9 is not busy.
  - Required: `busy` unchanged, `rf_we=1` for r9, `sb_err=1` and sticky until reset.
- WAW:
  - Stimulus: r3 is busy; decode presents `id_wen=1`, `id_wdst=3`.
  - Required: `id_stall=1` until r3 clears.
